// File: rtl/shift_seq_pkg.sv
// Shared EX-stage constants for the shift sequencer and the ALU mux.
// Contents: datapath widths, shift op codes, sequencer FSM state
// encodings and ALUctrl codes.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  // Shift op codes carried on op_i
  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_SRA = 2'b10;
  localparam logic [1:0] SHOP_RSV = 2'b11;

  // Sequencer FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // ALUctrl codes shared by the EX-stage result mux
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between ID_EX/EX control and the shift sequencer.
// Signals:
//   start_i  - shift request (sampled only while the sequencer is idle)
//   op_i     - shift op (SLL/SRL/SRA/reserved)
//   src_i    - operand rs1
//   shamt_i  - shift amount
//   flush_i  - pipeline flush, aborts the operation in progress
//   busy_o   - sequencer not idle
//   stall_o  - freeze IF/ID/EX while the result is pending
//   done_o   - one-cycle result-valid pulse
//   result_o - shift result, holds the last completed value
// Modports: master (pipeline side), slave (sequencer side).
interface shift_seq_if #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned SHAMT_W = riscv_pkg::SHAMT_W
);
  logic               start_i;
  logic [1:0]         op_i;
  logic [XLEN-1:0]    src_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               flush_i;
  logic               busy_o;
  logic               stall_o;
  logic               done_o;
  logic [XLEN-1:0]    result_o;

  modport master (
    output start_i, op_i, src_i, shamt_i, flush_i,
    input  busy_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, src_i, shamt_i, flush_i,
    output busy_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/shift_seq_step.sv
// Combinational single step of the shift sequencer.
// Ports:
//   shreg - current shift register value
//   op    - shift op (SLL zero-fills LSB, SRL zero-fills MSB, SRA sign-fills)
//   amt   - step amount (1, or 4 in the fast build)
//   next  - shift register value after this step
module shift_step
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] shreg,
  input  logic [1:0]      op,
  input  logic [2:0]      amt,
  output logic [XLEN-1:0] next
);

  always_comb begin
    next = shreg;
    case (op)
      SHOP_SLL: next = shreg << amt;
      SHOP_SRL: next = shreg >> amt;
      SHOP_SRA: next = XLEN'($signed(shreg) >>> amt);
      default:  next = shreg;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative multi-cycle shift sequencer (SLL/SRL/SRA) for the EX stage.
// Latches one request while idle, shifts the operand a step per cycle,
// stalls the front of the pipeline until the result is ready, then
// presents the result with a one-cycle done pulse.
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-high reset
//   sif   - shift_seq_if.slave request/response bundle
// Build option: define SHIFT_FAST_EN to shift by 4 per cycle while the
// remaining count is at least 4 (1 per cycle otherwise).
module shift_seq
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned SHAMT_W = riscv_pkg::SHAMT_W
) (
  input  logic      clk_i,
  input  logic      rst_i,
  shift_seq_if.slave sif
);

  logic [1:0]         state;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] cnt_dec;
  logic [XLEN-1:0]    shreg;
  logic [XLEN-1:0]    shreg_next;
  logic [XLEN-1:0]    result_q;
  logic [2:0]         step;
  logic               accept;
  logic               done_now;

  assign accept = (state == ST_IDLE) && sif.start_i && !sif.flush_i;

`ifdef SHIFT_FAST_EN
  assign step = (cnt >= SHAMT_W'(4)) ? 3'd4 : 3'd1;
`else
  assign step = 3'd1;
`endif

  assign cnt_dec = cnt - SHAMT_W'(step);

  shift_step #(.XLEN(XLEN)) u_step (
    .shreg (shreg),
    .op    (op),
    .amt   (step),
    .next  (shreg_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      op       <= SHOP_SLL;
      cnt      <= '0;
      shreg    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= sif.src_i;
            op    <= sif.op_i;
            cnt   <= sif.shamt_i;
            if ((sif.shamt_i == '0) || (sif.op_i == SHOP_RSV))
              state <= ST_DONE;
            else
              state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sif.flush_i) begin
            state <= ST_IDLE;
          end else begin
            shreg <= shreg_next;
            cnt   <= cnt_dec;
            if (cnt_dec == '0)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (!sif.flush_i)
            result_q <= shreg;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The final value already sits in shreg during DONE; it is committed to
  // result_q only when DONE completes unflushed, so a flush in DONE leaves
  // result_o at the previous completed value in that very cycle.
  assign done_now     = (state == ST_DONE) && !sif.flush_i;
  assign sif.done_o   = done_now;
  assign sif.result_o = done_now ? shreg : result_q;
  assign sif.busy_o   = (state != ST_IDLE);
  assign sif.stall_o  = accept || (state == ST_SHIFT);

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
Iterative multi-cycle shift sequencer for the EX stage. It provides SLL/SRL/SRA, which the single-cycle ALU does not implement. It accepts one shift request from ID_EX and shifts the latched operand one bit per cycle. It holds the pipeline via stall_o until the result is ready, then returns the result with a one-cycle done pulse for the EX/MEM mux.

Parameters:
XLEN, 32, datapath width
SHAMT_W, 5, shift-amount width (log2 XLEN)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
start_i  in  1  shift request from ID_EX; sampled only in IDLE
op_i  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
src_i  in  XLEN  operand rs1
shamt_i  in  SHAMT_W  shift amount (rs2[4:0] or imm[4:0])
flush_i  in  1  pipeline flush; aborts the operation in progress
busy_o  out  1  state != IDLE
stall_o  out  1  freeze IF/ID/EX while the result is pending
done_o  out  1  one-cycle pulse; result_o valid in that cycle
result_o  out  XLEN  shift result; holds the last completed value

Behaviour:
- Reset (async, rst_i=1): state=IDLE, cnt=0, shreg=0, op=00; busy_o=0, stall_o=0, done_o=0, result_o=0. A reset mid-operation discards it with no done pulse.
- Cycle numbering: cycle 0 is the cycle in which start_i=1 while in IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start_i && !flush_i, latch src_i→shreg, op_i→op, shamt_i→cnt.
  - Next state is SHIFT if shamt_i!=0.
  - Next state is DONE if shamt_i==0 or op_i==11. For op 11, result = src, shamt is ignored.
- SHIFT: each edge shifts shreg by 1 and decrements cnt.
  - SLL fills 0 at the LSB.
  - SRL fills 0 at the MSB.
  - SRA replicates shreg[XLEN-1].
  - When cnt reaches 0, go to DONE.
  - SHIFT occupies cycles 1..shamt.
- DONE: done_o=1 and result_o=shreg (registered output, updated on entry to DONE). Next state is IDLE unconditionally.
  - done_o fires in cycle shamt+1.
  - Back-to-back: start_i is accepted in the cycle after DONE, never in DONE itself.
- stall_o = (IDLE && start_i && !flush_i) || SHIFT. It is high in cycles 0..shamt and low in DONE, so the pipeline advances and captures the result.
- busy_o is high in SHIFT and DONE.
- start_i outside IDLE is ignored, with no queueing.
- flush_i in SHIFT or DONE: next state is IDLE; done_o is suppressed and result_o is unchanged.
  - flush_i has priority over start_i in the same cycle.
  - In DONE, flush_i also forces done_o=0 that cycle.
- Shift arithmetic is purely XLEN-bit; there is no carry/overflow output.

Optional Feature:
SHIFT_FAST_EN
- Defined: each SHIFT cycle shifts by 4 when cnt>=4, otherwise by 1. SHIFT length = floor(shamt/4) + (shamt mod 4), and done_o follows in the next cycle. Example: shamt=31 gives 10 SHIFT cycles, done_o in cycle 11. stall_o, flush and DONE rules are unchanged.
- Undefined: the 1-bit/cycle behaviour above; the 4-bit step logic is absent.

Decomposition:
- riscv_pkg holds:
  - XLEN and SHAMT_W constants
  - shift op codes SHOP_SLL=2'b00, SHOP_SRL=2'b01, SHOP_SRA=2'b10
  - FSM state encodings ST_IDLE/ST_SHIFT/ST_DONE
  - the ALUctrl codes, so EX-stage muxing shares one source
- One sub-module, shift_step: combinational, inputs shreg/op/step amount (1 or 4), output the next shreg. It is instantiated once, with the step selected by SHIFT_FAST_EN logic.

Test Plan:
1. SLL src=0x0000_0001 shamt=31 → stall_o high cycles 0..31, done_o pulse in cycle 32, result_o=0x8000_0000.
2. SRA src=0x8000_0000 shamt=4 → done_o in cycle 5, result_o=0xF800_0000. SRL with the same operands → 0x0800_0000.
3. shamt=0, src=0x1234_5678, op=SLL → stall_o high only in cycle 0, done_o in cycle 1, result_o=0x1234_5678. op=11 with shamt=7 → same timing and result.
4. SRL src=0xFFFF_FFFF shamt=10, flush_i in cycle 3 → busy_o=0 from cycle 4, no done_o, result_o keeps its prior value. A second start_i in cycle 2 is ignored.
5. rst_i asserted asynchronously mid-SHIFT → all outputs 0 immediately. start_i after release runs normally: SLL 0x3 by 2 → 0xC.
6. SHIFT_FAST_EN defined: SLL 0x1 by 31 → done_o in cycle 11, result_o=0x8000_0000. shamt=5 → done_o in cycle 3.
